reg_write_sequencer: RTL and testbench
======================================

Name: reg_write_sequencer

Overview:
- Upstream issue stage for the 1-to-10 register write-enable demultiplexer.
- Accepts register-write requests (destination index 0..9 plus data) through a valid/ready handshake and buffers them in a small FIFO.
- Issues one registered write per cycle as an enable pulse, a 4-bit select and data; the enable drives the demux data input and the select drives the demux select.
- Drops out-of-range destinations and flags them.

Parameters:
- DATA_W, 16, width of the write data path.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the issued-write counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  FIFO can accept; equals NOT full, from registered state.
- req_dest  input  4  destination register index; 0..9 valid.
- req_data  input  DATA_W  write data.
- stall  input  1  downstream cannot take a write this cycle.
- flush  input  1  discard all queued requests.
- err_clr  input  1  clears err_dest.
- we_out  output  1  one-cycle write pulse; feeds the demux data input.
- sel_out  output  4  destination select; feeds the demux select.
- wr_data  output  DATA_W  data accompanying we_out.
- busy  output  1  FIFO not empty.
- err_dest  output  1  sticky: an out-of-range destination was dropped.
- issue_cnt  output  CNT_W  count of writes issued (we_out pulses), wraps.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO pointers and count are 0.
  - we_out=0, sel_out=4'b0000, wr_data=0, err_dest=0, issue_cnt=0.
  - req_ready=1 and busy=0 after the edge.
- Push: occurs when req_valid && req_ready at an edge; {req_dest, req_data} is written at the write pointer.
- Pop: occurs when the FIFO is not empty && !stall && !flush.
  - Head dest 0..9: at the same edge, we_out<=1, sel_out<=dest, wr_data<=data, issue_cnt<=issue_cnt+1 (mod 2^CNT_W).
  - Head dest 10..15: entry discarded, we_out<=0, sel_out and wr_data hold, err_dest<=1, issue_cnt unchanged.
- Any cycle without a valid pop: we_out<=0; sel_out and wr_data hold their last values.
- Latency: a request accepted at edge N into an empty, unstalled FIFO produces we_out=1 during the cycle after edge N+1. There is no bypass.
- Throughput: one issue per cycle while the FIFO is not empty and stall=0.
- Simultaneous push and pop: allowed whenever not full; count is unchanged.
- Full: req_ready=0, so there is no push when full, even if a pop occurs in the same cycle.
- Empty: no pop; we_out=0 regardless of stall.
- Pointers wrap modulo DEPTH. Count is held in a separate register of width log2(DEPTH)+1 so full and empty are distinguished.
- Flush:
  - Has priority over push and pop at that edge; pointers and count go to 0 and we_out<=0.
  - A req_valid in the flush cycle is not accepted, even if req_ready=1. The requester must retry.
  - err_dest and issue_cnt are unaffected.
- Stall:
  - Freezes the pop only; pushes continue until full.
  - Stall asserted in the cycle after a pulse does not retract that pulse.
- err_dest:
  - err_clr clears it at the edge.
  - If an invalid pop and err_clr coincide, set wins (err_dest=1).
- rst mid-operation: all queued entries are lost and outputs take reset values at that edge; rst overrides flush.
- Implementation: one always block for the FIFO storage/pointers and one for the registered issue outputs. Storage has no reset requirement; contents are don't-care when not counted.

Test Plan:
- Reset then single request dest=3, data=16'hA5A5 with stall=0 -> accepted at edge 1; we_out=1, sel_out=3, wr_data=A5A5 for exactly one cycle after edge 2; issue_cnt=1; busy returns to 0.
- Hold stall=1 and push 5 requests, dest 0..4 -> first 4 accepted, req_ready=0 on the 5th; release stall -> four consecutive pulses with sel_out 0,1,2,3; the 5th request is then accepted and issued with sel_out=4.
- Queue dest 9, 12, 7 -> pulses with sel 9 then 7, with one gap cycle where we_out=0; err_dest=1; issue_cnt=2; sel_out holds 9 during the gap.
- err_clr asserted in the same cycle as an invalid pop (dest=15) -> err_dest stays 1; err_clr alone in the next cycle -> err_dest=0.
- Queue 3 entries under stall, assert flush together with req_valid -> FIFO empty, req_dest not accepted, busy=0, no we_out pulse; a subsequent request issues normally.
- issue_cnt wrap: 256 valid issues with CNT_W=8 -> issue_cnt returns to 0. Separately, assert rst while 2 entries are queued -> we_out=0, sel_out=0, and no further pulses.

Source files
------------

// File: rtl/reg_write_sequencer.sv
// Issue stage in front of the 1-to-10 register write demux: buffers write requests
// in a small FIFO and emits one registered write pulse with select and data per cycle.
module reg_write_sequencer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_dest,
  input  logic [DATA_W-1:0] req_data,
  input  logic              stall,
  input  logic              flush,
  input  logic              err_clr,
  output logic              we_out,
  output logic [3:0]        sel_out,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              err_dest,
  output logic [CNT_W-1:0]  issue_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAST_DEST = 4'd9;

  typedef struct packed {
    logic [3:0]        dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;

  logic            full, empty, push, pop, head_ok;
  entry_t          head;

  logic              we_d, err_d;
  logic [3:0]        sel_d;
  logic [DATA_W-1:0] data_d;
  logic [CNT_W-1:0]  cnt_d;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign req_ready = ~full;
  assign busy      = ~empty;

  // Flush blocks both sides so a request seen in the flush cycle must be retried.
  assign push    = req_valid && !full && !flush;
  assign pop     = !empty && !stall && !flush;
  assign head    = mem_q[rd_ptr_q];
  assign head_ok = (head.dest <= LAST_DEST);

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= '{dest: req_dest, data: req_data};
    end
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= AW'(wr_ptr_q + 1'b1);
      if (pop)  rd_ptr_q <= AW'(rd_ptr_q + 1'b1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    we_d   = 1'b0;
    sel_d  = sel_out;
    data_d = wr_data;
    cnt_d  = issue_cnt;
    err_d  = err_dest;
    if (pop && head_ok) begin
      we_d   = 1'b1;
      sel_d  = head.dest;
      data_d = head.data;
      cnt_d  = issue_cnt + CNT_W'(1);
    end
    // A dropped destination outranks a simultaneous clear.
    if (pop && !head_ok) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_out    <= 1'b0;
      sel_out   <= '0;
      wr_data   <= '0;
      err_dest  <= 1'b0;
      issue_cnt <= '0;
    end else begin
      we_out    <= we_d;
      sel_out   <= sel_d;
      wr_data   <= data_d;
      err_dest  <= err_d;
      issue_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Bench for reg_write_sequencer: directed vector table, corner sequences and
// randomized traffic compared cycle by cycle against a queue-based reference.
module tb_reg_write_sequencer;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst, req_valid, req_ready, stall, flush, err_clr;
  logic [3:0]        req_dest, sel_out;
  logic [DATA_W-1:0] req_data, wr_data;
  logic              we_out, busy, err_dest;
  logic [CNT_W-1:0]  issue_cnt;

  reg_write_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_data(req_data), .stall(stall), .flush(flush),
    .err_clr(err_clr), .we_out(we_out), .sel_out(sel_out), .wr_data(wr_data),
    .busy(busy), .err_dest(err_dest), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0]        d;
    logic [DATA_W-1:0] v;
  } ent_t;

  ent_t              q[$];
  logic              m_we, m_err;
  logic [3:0]        m_sel;
  logic [DATA_W-1:0] m_wd;
  logic [CNT_W-1:0]  m_cnt;

  typedef struct {
    logic              valid;
    logic [3:0]        dest;
    logic [DATA_W-1:0] data;
    logic              stall, flush, clr;
    logic              we;
    logic [3:0]        sel;
    logic [DATA_W-1:0] wd;
    logic              err;
    logic [CNT_W-1:0]  cnt;
    logic              ready, busy;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: advance the abstract queue model for one edge, clock, then compare.
  task automatic step();
    ent_t h;
    bit   do_push, do_pop, errset;
    if (rst) begin
      q.delete();
      m_we = 0; m_sel = 0; m_wd = 0; m_err = 0; m_cnt = 0;
    end else begin
      do_push = req_valid && (q.size() < DEPTH) && !flush;
      do_pop  = (q.size() > 0) && !stall && !flush;
      errset  = 0;
      m_we    = 0;
      if (flush) q.delete();
      else begin
        if (do_pop) begin
          h = q.pop_front();
          if (h.d <= 9) begin
            m_we = 1; m_sel = h.d; m_wd = h.v; m_cnt = m_cnt + 1'b1;
          end else errset = 1;
        end
        if (do_push) q.push_back('{d: req_dest, v: req_data});
      end
      if (errset) m_err = 1;
      else if (err_clr) m_err = 0;
    end
    @(posedge clk);
    #1;
    chk("we_out", int'(we_out), int'(m_we));
    chk("sel_out", int'(sel_out), int'(m_sel));
    chk("wr_data", int'(wr_data), int'(m_wd));
    chk("err_dest", int'(err_dest), int'(m_err));
    chk("issue_cnt", int'(issue_cnt), int'(m_cnt));
    chk("req_ready", int'(req_ready), int'(q.size() < DEPTH));
    chk("busy", int'(busy), int'(q.size() > 0));
  endtask

  task automatic idle();
    req_valid = 0; flush = 0; err_clr = 0;
  endtask

  initial begin
    logic [CNT_W-1:0] saved;
    rst = 1; req_valid = 0; req_dest = 0; req_data = 0;
    stall = 0; flush = 0; err_clr = 0;
    step();
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(issue_cnt), 0);
    rst = 0;

    //            valid dest data     stl fl clr  we sel wd       err cnt rdy busy
    tbl[0]  = '{1, 4'd3,  16'hA5A5, 0, 0, 0,   0, 0, 16'h0000, 0, 0, 1, 1};
    tbl[1]  = '{0, 4'd0,  16'h0000, 0, 0, 0,   1, 3, 16'hA5A5, 0, 1, 1, 0};
    tbl[2]  = '{0, 4'd0,  16'h0000, 0, 0, 0,   0, 3, 16'hA5A5, 0, 1, 1, 0};
    tbl[3]  = '{1, 4'd9,  16'h1111, 0, 0, 0,   0, 3, 16'hA5A5, 0, 1, 1, 1};
    tbl[4]  = '{1, 4'd12, 16'h2222, 0, 0, 0,   1, 9, 16'h1111, 0, 2, 1, 1};
    tbl[5]  = '{1, 4'd7,  16'h3333, 0, 0, 0,   0, 9, 16'h1111, 1, 2, 1, 1};
    tbl[6]  = '{0, 4'd0,  16'h0000, 0, 0, 0,   1, 7, 16'h3333, 1, 3, 1, 0};
    tbl[7]  = '{1, 4'd15, 16'h4444, 0, 0, 0,   0, 7, 16'h3333, 1, 3, 1, 1};
    tbl[8]  = '{0, 4'd0,  16'h0000, 0, 0, 1,   0, 7, 16'h3333, 1, 3, 1, 0};
    tbl[9]  = '{0, 4'd0,  16'h0000, 0, 0, 1,   0, 7, 16'h3333, 0, 3, 1, 0};
    tbl[10] = '{1, 4'd0,  16'h0005, 1, 0, 0,   0, 7, 16'h3333, 0, 3, 1, 1};
    tbl[11] = '{1, 4'd1,  16'h0006, 1, 1, 0,   0, 7, 16'h3333, 0, 3, 1, 0};
    tbl[12] = '{0, 4'd0,  16'h0000, 0, 0, 0,   0, 7, 16'h3333, 0, 3, 1, 0};

    for (int i = 0; i < 13; i++) begin
      req_valid = tbl[i].valid; req_dest = tbl[i].dest; req_data = tbl[i].data;
      stall = tbl[i].stall; flush = tbl[i].flush; err_clr = tbl[i].clr;
      step();
      chk($sformatf("v%0d_we", i), int'(we_out), int'(tbl[i].we));
      chk($sformatf("v%0d_sel", i), int'(sel_out), int'(tbl[i].sel));
      chk($sformatf("v%0d_wd", i), int'(wr_data), int'(tbl[i].wd));
      chk($sformatf("v%0d_err", i), int'(err_dest), int'(tbl[i].err));
      chk($sformatf("v%0d_cnt", i), int'(issue_cnt), int'(tbl[i].cnt));
      chk($sformatf("v%0d_ready", i), int'(req_ready), int'(tbl[i].ready));
      chk($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].busy));
    end
    idle();

    // Fill under stall: fifth request sees a full FIFO.
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1; req_dest = 4'(i); req_data = 16'(16'h100 + i);
      if (i == 4) chk("full_ready", int'(req_ready), 0);
      step();
    end
    stall = 0;
    req_dest = 4; req_data = 16'h0104;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_sel", int'(sel_out), i);
      chk("drain_we", int'(we_out), 1);
      if (i == 1) req_valid = 0;
    end
    step();
    chk("fifth_sel", int'(sel_out), 4);
    chk("fifth_we", int'(we_out), 1);
    idle();
    for (int i = 0; i < 3; i++) step();

    // Counter wraps after 256 valid issues.
    saved = m_cnt;
    for (int i = 0; i < 256; i++) begin
      req_valid = 1; req_dest = 4'($urandom_range(9)); req_data = 16'($urandom);
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) step();
    chk("wrap_cnt", int'(issue_cnt), int'(saved));

    // Reset with two entries queued.
    stall = 1; req_valid = 1;
    step(); step();
    idle(); stall = 0; rst = 1;
    step();
    chk("rst_mid_we", int'(we_out), 0);
    chk("rst_mid_sel", int'(sel_out), 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_pulse", int'(we_out), 0);
    end

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(3) != 0);
      req_dest  = ($urandom_range(7) == 0) ? 4'(10 + $urandom_range(5)) : 4'($urandom_range(9));
      req_data  = 16'($urandom);
      stall     = ($urandom_range(3) == 0);
      flush     = ($urandom_range(31) == 0);
      err_clr   = ($urandom_range(7) == 0);
      rst       = ($urandom_range(199) == 0);
      step();
    end
    rst = 0; idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
